// File: rtl/z80_bus_sync_if.sv
// Z80 pin bundle plus the clean event outputs produced by z80_bus_sync.
interface z80_bus_sync_if;
   logic [15:0] z80_a;
   logic [7:0]  z80_d_in;
   logic        z80_rd;
   logic        z80_wr;
   logic        z80_m1;
   logic        z80_iorq;
   logic        z80_mreq;
   logic        evt_valid;
   logic [2:0]  evt_type;
   logic [15:0] evt_addr;
   logic [7:0]  evt_data;
   logic        cycle_active;
   logic [7:0]  glitch_cnt;

   modport master (
      output z80_a, z80_d_in, z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq,
      input  evt_valid, evt_type, evt_addr, evt_data, cycle_active, glitch_cnt
   );

   modport slave (
      input  z80_a, z80_d_in, z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq,
      output evt_valid, evt_type, evt_addr, evt_data, cycle_active, glitch_cnt
   );
endinterface

// File: rtl/z80_bus_sync.sv
// Synchronizes and glitch-filters raw Z80 bus pins, emitting one clean event per bus cycle.
//   state    | meaning
//   IDLE     | bus idle or no candidate yet
//   QUALIFY  | candidate type seen, counting matching samples up to FILTER
//   ACTIVE   | one-clk event pulse with latched type/addr/data
//   WAIT_END | event emitted, waiting for iorq and mreq to both go idle
module z80_bus_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 2
) (
   input logic          clk,
   input logic          rst,
   z80_bus_sync_if.slave bus
);
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_QUALIFY  = 2'd1;
   localparam logic [1:0] ST_ACTIVE   = 2'd2;
   localparam logic [1:0] ST_WAIT_END = 2'd3;

   localparam logic [2:0] T_NONE     = 3'd0;
   localparam logic [2:0] T_M1_FETCH = 3'd1;
   localparam logic [2:0] T_INT_ACK  = 3'd2;
   localparam logic [2:0] T_IO_RD    = 3'd3;
   localparam logic [2:0] T_IO_WR    = 3'd4;
   localparam logic [2:0] T_MEM_RD   = 3'd5;
   localparam logic [2:0] T_MEM_WR   = 3'd6;

   localparam int         SW       = 29;
   localparam logic [SW-1:0] SYNC_RST = {24'h0, 5'b11111};
   localparam logic [4:0] FILTER_W = 5'(FILTER);

   logic [SW-1:0] sync_q [SYNC_STAGES];
   logic [SW-1:0] sync_d [SYNC_STAGES];
   logic [SW-1:0] smp;

   always_comb begin
      sync_d[0] = {bus.z80_a, bus.z80_d_in, bus.z80_rd, bus.z80_wr,
                   bus.z80_m1, bus.z80_iorq, bus.z80_mreq};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign smp = sync_q[SYNC_STAGES-1];

   logic [15:0] s_a;
   logic [7:0]  s_d;
   logic        s_rd, s_wr, s_m1, s_iorq, s_mreq, bus_idle;
   logic [2:0]  cur_type;

   assign s_a      = smp[28:13];
   assign s_d      = smp[12:5];
   assign s_rd     = smp[4];
   assign s_wr     = smp[3];
   assign s_m1     = smp[2];
   assign s_iorq   = smp[1];
   assign s_mreq   = smp[0];
   assign bus_idle = s_iorq & s_mreq;

   always_comb begin
      cur_type = T_NONE;
      if (!s_mreq && !s_rd && !s_m1)      cur_type = T_M1_FETCH;
      else if (!s_iorq && !s_m1)          cur_type = T_INT_ACK;
      else if (!s_iorq && !s_rd && s_m1)  cur_type = T_IO_RD;
      else if (!s_iorq && !s_wr && s_m1)  cur_type = T_IO_WR;
      else if (!s_mreq && !s_rd && s_m1)  cur_type = T_MEM_RD;
      else if (!s_mreq && !s_wr && s_m1)  cur_type = T_MEM_WR;
   end

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  cand_q, cand_d;
   logic [7:0]  glitch_q, glitch_d;
   logic [2:0]  evt_type_q, evt_type_d;
   logic [15:0] evt_addr_q, evt_addr_d;
   logic [7:0]  evt_data_q, evt_data_d;
   logic [4:0]  cnt_inc;
   logic        go_active;

   assign cnt_inc = {1'b0, cnt_q} + 5'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cand_d     = cand_q;
      glitch_d   = glitch_q;
      evt_type_d = evt_type_q;
      evt_addr_d = evt_addr_q;
      evt_data_d = evt_data_q;
      go_active  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cur_type != T_NONE) begin
               cand_d = cur_type;
               cnt_d  = 4'd1;
               if (FILTER_W == 5'd1) go_active = 1'b1;
               else                  state_d   = ST_QUALIFY;
            end
         end
         ST_QUALIFY: begin
            if (cur_type == cand_q) begin
               cnt_d = cnt_inc[3:0];
               if (cnt_inc == FILTER_W) go_active = 1'b1;
            end else begin
               if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: state_d = ST_WAIT_END;
         default: begin
            if (bus_idle) begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end
         end
      endcase
      if (go_active) begin
         state_d    = ST_ACTIVE;
         evt_type_d = cur_type;
         evt_addr_d = s_a;
         // Only write cycles carry meaningful data on the bus
         evt_data_d = (cur_type == T_IO_WR || cur_type == T_MEM_WR) ? s_d : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         cand_q     <= T_NONE;
         glitch_q   <= 8'd0;
         evt_type_q <= T_NONE;
         evt_addr_q <= 16'd0;
         evt_data_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         glitch_q   <= glitch_d;
         evt_type_q <= evt_type_d;
         evt_addr_q <= evt_addr_d;
         evt_data_q <= evt_data_d;
      end
   end

   assign bus.evt_valid    = (state_q == ST_ACTIVE);
   assign bus.cycle_active = (state_q == ST_ACTIVE) || (state_q == ST_WAIT_END);
   assign bus.evt_type     = evt_type_q;
   assign bus.evt_addr     = evt_addr_q;
   assign bus.evt_data     = evt_data_q;
   assign bus.glitch_cnt   = glitch_q;
endmodule

// File: tb/tb_z80_bus_sync.sv
// Directed bench for z80_bus_sync: default instance plus a FILTER=1 instance, event scoreboard.
module tb_z80_bus_sync;
   typedef struct {
      logic [2:0]  t;
      logic [15:0] a;
      logic [7:0]  d;
   } evt_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n_ev0  = 0;
   int   n_ev1  = 0;
   logic prev_v0 = 1'b0;
   logic prev_v1 = 1'b0;
   evt_t q0[$];
   evt_t q1[$];

   always #5 clk = ~clk;

   z80_bus_sync_if bus0();
   z80_bus_sync_if bus1();

   z80_bus_sync #(.SYNC_STAGES(2), .FILTER(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   z80_bus_sync #(.SYNC_STAGES(2), .FILTER(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      bus0.z80_rd = 1'b1; bus0.z80_wr = 1'b1; bus0.z80_m1 = 1'b1;
      bus0.z80_iorq = 1'b1; bus0.z80_mreq = 1'b1;
   endtask

   task automatic push0(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
      evt_t e;
      e.t = t; e.a = a; e.d = d;
      q0.push_back(e);
   endtask

   always @(negedge clk) begin
      evt_t e;
      if (bus0.evt_valid === 1'b1) begin
         n_ev0++;
         chk("dut0_no_double_pulse", {31'd0, prev_v0}, 32'd0);
         chk("dut0_event_expected", {31'd0, q0.size() != 0}, 32'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("dut0_evt_type", {29'd0, bus0.evt_type}, {29'd0, e.t});
            chk("dut0_evt_addr", {16'd0, bus0.evt_addr}, {16'd0, e.a});
            chk("dut0_evt_data", {24'd0, bus0.evt_data}, {24'd0, e.d});
         end
      end
      prev_v0 = (bus0.evt_valid === 1'b1);
   end

   always @(negedge clk) begin
      evt_t e;
      if (bus1.evt_valid === 1'b1) begin
         n_ev1++;
         chk("dut1_no_double_pulse", {31'd0, prev_v1}, 32'd0);
         chk("dut1_event_expected", {31'd0, q1.size() != 0}, 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("dut1_evt_type", {29'd0, bus1.evt_type}, {29'd0, e.t});
            chk("dut1_evt_addr", {16'd0, bus1.evt_addr}, {16'd0, e.a});
            chk("dut1_evt_data", {24'd0, bus1.evt_data}, {24'd0, e.d});
         end
      end
      prev_v1 = (bus1.evt_valid === 1'b1);
   end

   initial begin
      int   waited;
      evt_t e;
      rst = 1'b1;
      bus0.z80_a = 16'h0; bus0.z80_d_in = 8'h0; idle0();
      bus1.z80_a = 16'h0; bus1.z80_d_in = 8'h0;
      bus1.z80_rd = 1'b1; bus1.z80_wr = 1'b1; bus1.z80_m1 = 1'b1;
      bus1.z80_iorq = 1'b1; bus1.z80_mreq = 1'b1;

      // 1: reset then idle bus
      tick(3);
      rst = 1'b0;
      tick(20);
      chk("idle_no_events", n_ev0, 0);
      chk("idle_glitch_cnt", {24'd0, bus0.glitch_cnt}, 0);
      chk("idle_evt_type", {29'd0, bus0.evt_type}, 0);
      chk("idle_evt_addr", {16'd0, bus0.evt_addr}, 0);
      chk("idle_evt_data", {24'd0, bus0.evt_data}, 0);
      chk("idle_cycle_active", {31'd0, bus0.cycle_active}, 0);

      // 2: IO write, latency and cycle_active end
      bus0.z80_a = 16'h3039; bus0.z80_d_in = 8'h55;
      bus0.z80_iorq = 1'b0; bus0.z80_wr = 1'b0;
      push0(3'd4, 16'h3039, 8'h55);
      tick(3);
      chk("iowr_not_before_edge4", {31'd0, bus0.evt_valid}, 0);
      tick(1);
      chk("iowr_valid_at_edge4", {31'd0, bus0.evt_valid}, 1);
      chk("iowr_cycle_active", {31'd0, bus0.cycle_active}, 1);
      tick(1);
      chk("iowr_valid_single", {31'd0, bus0.evt_valid}, 0);
      chk("iowr_type_held", {29'd0, bus0.evt_type}, 4);
      tick(3);
      idle0();
      tick(2);
      chk("iowr_active_until_end", {31'd0, bus0.cycle_active}, 1);
      tick(1);
      chk("iowr_active_falls", {31'd0, bus0.cycle_active}, 0);
      chk("iowr_addr_held", {16'd0, bus0.evt_addr}, 32'h3039);
      tick(3);

      // 3: M1 fetch, then type change mid-cycle without idle
      bus0.z80_a = 16'h0000; bus0.z80_d_in = 8'hAA;
      bus0.z80_mreq = 1'b0; bus0.z80_rd = 1'b0; bus0.z80_m1 = 1'b0;
      push0(3'd1, 16'h0000, 8'h00);
      tick(6);
      bus0.z80_m1 = 1'b1;
      tick(8);
      chk("m1_single_event", n_ev0, 2);
      chk("m1_still_active", {31'd0, bus0.cycle_active}, 1);
      idle0();
      tick(5);
      chk("m1_cycle_end", {31'd0, bus0.cycle_active}, 0);

      // 4: single-clock strobe glitches
      bus0.z80_iorq = 1'b0; bus0.z80_rd = 1'b0;
      tick(1);
      idle0();
      tick(4);
      chk("glitch_cnt_one", {24'd0, bus0.glitch_cnt}, 1);
      for (int i = 0; i < 299; i++) begin
         bus0.z80_iorq = 1'b0; bus0.z80_rd = 1'b0;
         tick(1);
         idle0();
         tick(4);
      end
      chk("glitch_cnt_saturated", {24'd0, bus0.glitch_cnt}, 255);
      chk("glitch_no_events", n_ev0, 2);

      // 5: FILTER=1 instance, IO read
      bus1.z80_a = 16'h3041; bus1.z80_iorq = 1'b0; bus1.z80_rd = 1'b0;
      e.t = 3'd3; e.a = 16'h3041; e.d = 8'h00;
      q1.push_back(e);
      tick(2);
      chk("f1_not_before_edge3", {31'd0, bus1.evt_valid}, 0);
      tick(1);
      chk("f1_valid_at_edge3", {31'd0, bus1.evt_valid}, 1);
      bus1.z80_iorq = 1'b1; bus1.z80_rd = 1'b1;
      tick(6);
      chk("f1_one_event", n_ev1, 1);

      // 6: reset while in WAIT_END of an IO write
      bus0.z80_a = 16'h1234; bus0.z80_d_in = 8'h9A;
      bus0.z80_iorq = 1'b0; bus0.z80_wr = 1'b0;
      push0(3'd4, 16'h1234, 8'h9A);
      tick(6);
      chk("rst_pre_wait_end", {31'd0, bus0.cycle_active}, 1);
      chk("rst_pre_event_seen", n_ev0, 3);
      rst = 1'b1;
      tick(1);
      chk("rst_evt_valid", {31'd0, bus0.evt_valid}, 0);
      chk("rst_evt_type", {29'd0, bus0.evt_type}, 0);
      chk("rst_evt_addr", {16'd0, bus0.evt_addr}, 0);
      chk("rst_evt_data", {24'd0, bus0.evt_data}, 0);
      chk("rst_cycle_active", {31'd0, bus0.cycle_active}, 0);
      chk("rst_glitch_cnt", {24'd0, bus0.glitch_cnt}, 0);
      rst = 1'b0;
      push0(3'd4, 16'h1234, 8'h9A);
      waited = 0;
      while (n_ev0 < 4 && waited < 20) begin
         tick(1);
         waited++;
      end
      chk("rst_reevent_seen", n_ev0, 4);
      tick(4);
      chk("rst_reevent_single", n_ev0, 4);
      idle0();
      tick(5);
      chk("final_cycle_end", {31'd0, bus0.cycle_active}, 0);
      chk("dut0_queue_drained", q0.size(), 0);
      chk("dut1_queue_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
